zero_count_checker: RTL and testbench

ZERO_COUNT_CHECKER -- requirements
Module: zero_count_checker

---
 rtl/zero_count_checker.sv | 103 ++++++++++
 tb/tb_zero_count_checker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/zero_count_checker.sv
// zero_count_checker: deserializes 16-bit LSB-first frames with X/Y parity flags, checks them against the zero count, and aborts stalled frames
module zero_count_checker #(
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [4:0]  zero_cnt,
  output logic        x_ok,
  output logic        y_ok,
  output logic        err,
  output logic        abort
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {RX_DATA, RX_X, RX_Y, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic [4:0] zcnt_q, zcnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic x_q, x_d, y_q, y_d, abort_q, abort_d;
  logic xfer, active;
  assign in_ready = state_q != HOLD;
  assign xfer = in_valid && in_ready;
  assign active = (state_q == RX_DATA && idx_q != 4'd0) || state_q == RX_X || state_q == RX_Y;
  assign out_valid = state_q == HOLD;
  assign out_data = data_q;
  assign zero_cnt = zcnt_q;
  assign x_ok = out_valid && (x_q == ~zcnt_q[0]);
  assign y_ok = out_valid && (y_q == (zcnt_q % 5'd3 == 5'd0));
  assign err = out_valid && !(x_ok && y_ok);
  assign abort = abort_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    data_d = data_q;
    zcnt_d = zcnt_q;
    idle_d = idle_q;
    x_d = x_q;
    y_d = y_q;
    abort_d = 1'b0;
    if (xfer) begin
      idle_d = '0;
      case (state_q)
        RX_DATA: begin
          data_d[idx_q] = in_bit;
          zcnt_d = (!in_bit && zcnt_q != 5'd16) ? zcnt_q + 5'd1 : zcnt_q;
          idx_d = idx_q + 4'd1;
          state_d = idx_q == 4'd15 ? RX_X : RX_DATA;
        end
        RX_X: begin
          x_d = in_bit;
          state_d = RX_Y;
        end
        default: begin
          y_d = in_bit;
          state_d = HOLD;
        end
      endcase
    end else if (active) begin
      if (int'(idle_q) == IDLE_TIMEOUT - 1) begin
        abort_d = 1'b1;
        state_d = RX_DATA;
        idx_d = '0;
        zcnt_d = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
    if (state_q == HOLD && out_ready) begin
      state_d = RX_DATA;
      idx_d = '0;
      zcnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_DATA;
      idx_q <= '0;
      data_q <= '0;
      zcnt_q <= '0;
      idle_q <= '0;
      x_q <= 1'b0;
      y_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      zcnt_q <= zcnt_d;
      idle_q <= idle_d;
      x_q <= x_d;
      y_q <= y_d;
      abort_q <= abort_d;
    end
  end
endmodule

// File: tb/tb_zero_count_checker.sv
// tb_zero_count_checker: directed self-checking bench for zero_count_checker
module tb_zero_count_checker;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, x_ok, y_ok, err, abort;
  logic [15:0] out_data;
  logic [4:0] zero_cnt;
  int passed = 0, total = 0, ab, ov;
  zero_count_checker #(.IDLE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .zero_cnt(zero_cnt),
    .x_ok(x_ok), .y_ok(y_ok), .err(err), .abort(abort)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [17:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      in_bit = f[i];
      tick();
    end
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n, output int a, output int v);
    a = 0;
    v = 0;
    repeat (n) begin
      tick();
      a += int'(abort);
      v += int'(out_valid);
    end
  endtask
  task automatic result(input string tag, input logic [15:0] d, input logic [4:0] z, input logic xo, input logic yo, input logic e);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_zcnt"}, zero_cnt, z);
    chk({tag, "_xok"}, x_ok, xo);
    chk({tag, "_yok"}, y_ok, yo);
    chk({tag, "_err"}, err, e);
    chk({tag, "_rdy"}, in_ready, 0);
  endtask
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, out_valid, 0);
    chk({tag, "_hs_rdy"}, in_ready, 1);
    chk({tag, "_hs_zcnt"}, zero_cnt, 0);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_zcnt", zero_cnt, 0);
    chk("rst_xok", x_ok, 0);
    chk("rst_yok", y_ok, 0);
    chk("rst_err", err, 0);
    chk("rst_abort", abort, 0);
    send({1'b1, 1'b1, 16'hFFFF}, 0, 16);
    chk("lat_before_y", out_valid, 0);
    send({1'b1, 1'b1, 16'hFFFF}, 17, 17);
    result("ffff", 16'hFFFF, 5'd0, 1, 1, 0);
    handshake("ffff");
    send({1'b1, 1'b1, 16'h0000}, 0, 17);
    result("0000", 16'h0000, 5'd16, 1, 0, 1);
    handshake("0000");
    send({1'b1, 1'b0, 16'hFFF8}, 0, 17);
    result("fff8", 16'hFFF8, 5'd3, 1, 1, 0);
    handshake("fff8");
    send({1'b1, 1'b1, 16'hFFF0}, 0, 17);
    result("fff0", 16'hFFF0, 5'd4, 1, 0, 1);
    handshake("fff0");
    send({1'b0, 1'b1, 16'hFFFE}, 0, 17);
    result("fffe", 16'hFFFE, 5'd1, 0, 1, 1);
    handshake("fffe");
    send({1'b0, 1'b0, 16'h1234}, 0, 17);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_bit = i[0];
      tick();
    end
    in_valid = 1'b0;
    result("bp", 16'h1234, 5'd11, 1, 1, 0);
    handshake("bp");
    idle(20, ab, ov);
    chk("gap_abort", ab, 0);
    chk("gap_valid", ov, 0);
    send({1'b1, 1'b1, 16'h0000}, 0, 4);
    chk("to_zcnt_pre", zero_cnt, 5);
    idle(7, ab, ov);
    chk("to_abort_7", ab, 0);
    tick();
    chk("to_abort_pulse", abort, 1);
    chk("to_zcnt_post", zero_cnt, 0);
    idle(10, ab, ov);
    chk("to_abort_once", ab, 0);
    chk("to_valid", ov, 0);
    send({1'b1, 1'b0, 16'hFFF8}, 0, 17);
    result("to_next", 16'hFFF8, 5'd3, 1, 1, 0);
    handshake("to_next");
    send({1'b1, 1'b1, 16'hFFFF}, 0, 4);
    idle(7, ab, ov);
    send({1'b1, 1'b1, 16'hFFFF}, 5, 5);
    chk("edge_abort", ab + int'(abort), 0);
    send({1'b1, 1'b1, 16'hFFFF}, 6, 17);
    result("edge", 16'hFFFF, 5'd0, 1, 1, 0);
    handshake("edge");
    send({1'b1, 1'b1, 16'h0000}, 0, 9);
    chk("mid_zcnt", zero_cnt, 10);
    rst = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b0;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mrst_zcnt", zero_cnt, 0);
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_abort", abort, 0);
    idle(20, ab, ov);
    chk("mrst_idle_abort", ab, 0);
    chk("mrst_idle_valid", ov, 0);
    send({1'b0, 1'b1, 16'h00FF}, 0, 17);
    result("post_rst", 16'h00FF, 5'd8, 1, 1, 0);
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("hold_rst_valid", out_valid, 0);
    chk("hold_rst_data", out_data, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
